// File: rtl/bsk_prm_com_out.sv
// rtl/bsk_prm_com_out.sv - PRM receiver relay output stage with filter, hold and CPU watchdog
//
// Purpose:
//   Takes the active-low command lines and terminal enable from the PRM
//   command register and drives the terminal relays. Each channel is
//   synchronised, glitch filtered and stretched to a minimum hold time.
//   A CPU-refresh watchdog forces every relay off if the processor stops
//   writing.
//
// Ports:
//   iClk     in   1      system clock
//   iRes     in   1      asynchronous active-low reset
//   iCom     in   WIDTH  command lines, active low, asynchronous
//   iEnable  in   1      terminal enable, active low, asynchronous
//   iKick    in   1      CPU write strobe, active low; falling edge refreshes watchdog
//   oRelay   out  WIDTH  relay drive, active low, registered
//   oWdtErr  out  1      watchdog tripped, registered
//   oRun     out  1      watchdog in RUN, registered

module bsk_prm_com_out #(
    parameter int          WIDTH  = 16,
    parameter int          FILTER = 4,
    parameter logic [15:0] HOLD   = 16'd1000,
    parameter logic [23:0] WDT    = 24'd500000
) (
    input  logic             iClk,
    input  logic             iRes,
    input  logic [WIDTH-1:0] iCom,
    input  logic             iEnable,
    input  logic             iKick,
    output logic [WIDTH-1:0] oRelay,
    output logic             oWdtErr,
    output logic             oRun
);

    typedef enum logic [1:0] {
        ST_DIS  = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRIP = 2'd2
    } state_t;

    localparam logic [3:0]  FILT_LAST = 4'(FILTER - 1);
    localparam logic [23:0] WDT_LAST  = WDT - 24'd1;

    logic [WIDTH-1:0]       com_s1_q, com_s1_d, com_s2_q, com_s2_d;
    logic                   en_s1_q, en_s1_d, en_s2_q, en_s2_d;
    logic                   kick_s1_q, kick_s1_d, kick_s2_q, kick_s2_d;
    logic                   kick_s3_q, kick_s3_d;
    logic [WIDTH-1:0]       flt_q, flt_d;
    logic [WIDTH-1:0][3:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0][15:0] hold_q, hold_d;
    state_t                 state_q, state_d;
    logic [23:0]            wdt_q, wdt_d;
    logic [WIDTH-1:0]       relay_q, relay_d;
    logic                   err_q, err_d;
    logic                   run_q, run_d;
    logic                   kick;
    logic [WIDTH-1:0]       active;

    always_comb begin
        com_s1_d  = iCom;
        com_s2_d  = com_s1_q;
        en_s1_d   = iEnable;
        en_s2_d   = en_s1_q;
        kick_s1_d = iKick;
        kick_s2_d = kick_s1_q;
        kick_s3_d = kick_s2_q;

        // Third kick flop only remembers the previous synchronised level.
        kick = ~kick_s2_q & kick_s3_q;

        flt_d  = flt_q;
        cnt_d  = '0;
        hold_d = hold_q;
        active = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (com_s2_q[i] != flt_q[i]) begin
                if (cnt_q[i] == FILT_LAST) begin
                    flt_d[i] = com_s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
            // A fresh assertion reloads only when no hold is still running.
            if (flt_q[i] && !flt_d[i] && (hold_q[i] == 16'd0)) begin
                hold_d[i] = HOLD;
            end else if (hold_q[i] != 16'd0) begin
                hold_d[i] = hold_q[i] - 16'd1;
            end
            active[i] = ~flt_d[i] | (hold_d[i] != 16'd0);
        end

        state_d = state_q;
        wdt_d   = wdt_q;
        case (state_q)
            ST_DIS: begin
                wdt_d = '0;
                if (!en_s2_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (kick) begin
                    wdt_d = '0;
                end else if (wdt_q == WDT_LAST) begin
                    state_d = ST_TRIP;
                    wdt_d   = '0;
                end else begin
                    wdt_d = wdt_q + 24'd1;
                end
            end
            ST_TRIP: begin
                wdt_d = '0;
                if (kick) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_DIS;
                wdt_d   = '0;
            end
        endcase
        // Losing the terminal enable beats any kick.
        if (en_s2_q) begin
            state_d = ST_DIS;
            wdt_d   = '0;
        end

        // Outputs follow the next state so gating acts on the entry clock.
        relay_d = (state_d == ST_RUN) ? ~active : '1;
        run_d   = (state_d == ST_RUN);
        err_d   = (state_d == ST_TRIP);
    end

    always_ff @(posedge iClk or negedge iRes) begin
        if (!iRes) begin
            com_s1_q  <= '1;
            com_s2_q  <= '1;
            en_s1_q   <= 1'b1;
            en_s2_q   <= 1'b1;
            kick_s1_q <= 1'b1;
            kick_s2_q <= 1'b1;
            kick_s3_q <= 1'b1;
            flt_q     <= '1;
            cnt_q     <= '0;
            hold_q    <= '0;
            state_q   <= ST_DIS;
            wdt_q     <= '0;
            relay_q   <= '1;
            err_q     <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            com_s1_q  <= com_s1_d;
            com_s2_q  <= com_s2_d;
            en_s1_q   <= en_s1_d;
            en_s2_q   <= en_s2_d;
            kick_s1_q <= kick_s1_d;
            kick_s2_q <= kick_s2_d;
            kick_s3_q <= kick_s3_d;
            flt_q     <= flt_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            state_q   <= state_d;
            wdt_q     <= wdt_d;
            relay_q   <= relay_d;
            err_q     <= err_d;
            run_q     <= run_d;
        end
    end

    assign oRelay  = relay_q;
    assign oWdtErr = err_q;
    assign oRun    = run_q;

endmodule

// File: tb/tb_bsk_prm_com_out.sv
// tb/tb_bsk_prm_com_out.sv - bench for bsk_prm_com_out

module tb_bsk_prm_com_out;

    localparam int WIDTH  = 16;
    localparam int FILTER = 4;
    localparam int HOLD   = 8;
    localparam int WDT    = 100;
    localparam int MAXC   = 8192;
    localparam int M_OFF  = 0;
    localparam int M_RUN  = 1;
    localparam int M_TRIP = 2;

    logic              iClk = 1'b0;
    logic              iRes;
    logic [WIDTH-1:0]  iCom;
    logic              iEnable;
    logic              iKick;
    logic [WIDTH-1:0]  oRelay;
    logic              oWdtErr;
    logic              oRun;

    always #5 iClk = ~iClk;

    bsk_prm_com_out #(
        .WIDTH  (WIDTH),
        .FILTER (FILTER),
        .HOLD   (16'(HOLD)),
        .WDT    (24'(WDT))
    ) dut (
        .iClk    (iClk),
        .iRes    (iRes),
        .iCom    (iCom),
        .iEnable (iEnable),
        .iKick   (iKick),
        .oRelay  (oRelay),
        .oWdtErr (oWdtErr),
        .oRun    (oRun)
    );

    // Reference model: raw input history per counted clock edge, plus the
    // filtered level, hold end time and watchdog refresh time per rule.
    logic [WIDTH-1:0] com_h  [0:MAXC-1];
    logic             en_h   [0:MAXC-1];
    logic             kick_h [0:MAXC-1];
    int               n        = 1;
    int               rst_edge = 1;
    logic [WIDTH-1:0] m_f;
    int               hold_until [WIDTH];
    int               m_st;
    int               refresh;
    logic [WIDTH-1:0] m_relay;
    int               total  = 0;
    int               passed = 0;
    bit               auto_kick;
    int               ak_phase;
    int               lows;
    int               idx;

    function automatic logic [WIDTH-1:0] com_at(input int k);
        if (k < rst_edge) return '1;
        return com_h[k];
    endfunction

    function automatic logic en_at(input int k);
        if (k < rst_edge) return 1'b1;
        return en_h[k];
    endfunction

    function automatic logic kick_at(input int k);
        if (k < rst_edge) return 1'b1;
        return kick_h[k];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) begin
            passed = passed + 1;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_f     = '1;
        m_st    = M_OFF;
        refresh = 0;
        m_relay = '1;
        for (int i = 0; i < WIDTH; i++) hold_until[i] = 0;
    endtask

    task automatic model_edge(input int k);
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] h;
        logic             se;
        logic             kk;
        bit               diff;
        s  = com_at(k - 2);
        se = en_at(k - 2);
        kk = !kick_at(k - 2) && kick_at(k - 3);
        for (int i = 0; i < WIDTH; i++) begin
            diff = 1'b1;
            for (int j = 0; j < FILTER; j++) begin
                h = com_at(k - 2 - j);
                if (h[i] == m_f[i]) diff = 1'b0;
            end
            if (diff) begin
                if (m_f[i] == 1'b1 && (k - 1) >= hold_until[i]) hold_until[i] = k + HOLD;
                m_f[i] = s[i];
            end
        end
        if (se) begin
            m_st = M_OFF;
        end else begin
            case (m_st)
                M_OFF: begin
                    m_st    = M_RUN;
                    refresh = k;
                end
                M_RUN: begin
                    if (kk) refresh = k;
                    else if (k - refresh == WDT) m_st = M_TRIP;
                end
                default: begin
                    if (kk) begin
                        m_st    = M_RUN;
                        refresh = k;
                    end
                end
            endcase
        end
        for (int i = 0; i < WIDTH; i++)
            m_relay[i] = !(m_st == M_RUN && (m_f[i] == 1'b0 || k < hold_until[i]));
    endtask

    task automatic step();
        @(posedge iClk);
        if (n >= MAXC) begin
            $display("FAIL cycle_budget observed=%0d expected<%0d", n, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        com_h[n]  = iCom;
        en_h[n]   = iEnable;
        kick_h[n] = iKick;
        model_edge(n);
        #1;
        chk("cycle", 32'({oRelay, oWdtErr, oRun}),
            32'({m_relay, (m_st == M_TRIP), (m_st == M_RUN)}));
        n = n + 1;
        if (auto_kick) begin
            ak_phase = ak_phase + 1;
            iKick = ((ak_phase % 32) < 2) ? 1'b0 : 1'b1;
        end
    endtask

    initial begin
        iRes = 1'b0; iCom = '1; iEnable = 1'b1; iKick = 1'b1;
        auto_kick = 1'b0; ak_phase = 0;
        model_reset();
        repeat (2) @(posedge iClk);
        #1;
        chk("rst_relay", 32'(oRelay), 32'hFFFF);
        chk("rst_flags", 32'({oWdtErr, oRun}), 32'd0);
        iRes = 1'b1; rst_edge = n;
        step(); step();

        // enable and first command
        iEnable = 1'b0;
        step(); step();
        chk("run_early", 32'(oRun), 32'd0);
        step();
        chk("run_on", 32'(oRun), 32'd1);
        auto_kick = 1'b1;
        iCom = 16'hFFFE;
        repeat (5) step();
        chk("relay_lat5", 32'(oRelay), 32'hFFFF);
        step();
        chk("relay_lat6", 32'(oRelay), 32'hFFFE);

        // glitch reject and minimum pulse
        lows = 0;
        iCom[3] = 1'b0;
        repeat (3) begin step(); if (!oRelay[3]) lows++; end
        iCom[3] = 1'b1;
        repeat (12) begin step(); if (!oRelay[3]) lows++; end
        chk("glitch3", 32'(lows), 32'd0);
        lows = 0;
        iCom[3] = 1'b0;
        repeat (4) begin step(); if (!oRelay[3]) lows++; end
        iCom[3] = 1'b1;
        repeat (16) begin step(); if (!oRelay[3]) lows++; end
        chk("pulse4_low", 32'(lows), 32'd8);

        // hold stretching and long pulse
        lows = 0;
        iCom[5] = 1'b0;
        repeat (5) begin step(); if (!oRelay[5]) lows++; end
        iCom[5] = 1'b1;
        repeat (20) begin step(); if (!oRelay[5]) lows++; end
        chk("hold8", 32'(lows), 32'd8);
        lows = 0;
        iCom[5] = 1'b0;
        repeat (20) begin step(); if (!oRelay[5]) lows++; end
        iCom[5] = 1'b1;
        repeat (5) begin step(); if (!oRelay[5]) lows++; end
        chk("hold_long", 32'(lows), 32'd20);
        chk("rel_5", 32'(oRelay[5]), 32'd0);
        step();
        chk("rel_6", 32'(oRelay[5]), 32'd1);

        // watchdog trip and recovery
        auto_kick = 1'b0; iKick = 1'b1; iCom = '0;
        repeat (4) step();
        iKick = 1'b0;
        repeat (102) step();
        chk("pre_trip", 32'({oRelay, oWdtErr}), 32'({16'h0000, 1'b0}));
        step();
        chk("trip", 32'({oRelay, oWdtErr, oRun}), 32'({16'hFFFF, 1'b1, 1'b0}));
        iKick = 1'b1;
        repeat (3) step();
        iKick = 1'b0;
        step(); step();
        chk("trip_hold", 32'(oWdtErr), 32'd1);
        step();
        chk("recover", 32'({oRelay, oWdtErr, oRun}), 32'({16'h0000, 1'b0, 1'b1}));

        // kick on the terminal count
        iKick = 1'b1;
        repeat (97) step();
        iKick = 1'b0;
        repeat (3) step();
        chk("tc_kick", 32'({oWdtErr, oRun}), 32'b01);
        repeat (99) step();
        chk("tc_restart_pre", 32'(oWdtErr), 32'd0);
        step();
        chk("tc_restart_trip", 32'(oWdtErr), 32'd1);

        // disable during a hold while a kick arrives
        iKick = 1'b1;
        step(); step();
        iKick = 1'b0;
        repeat (3) step();
        chk("rerun", 32'(oRun), 32'd1);
        iKick = 1'b1; iCom = '1;
        repeat (8) step();
        iCom = '0;
        repeat (5) step();
        iCom = '1;
        repeat (5) step();
        iEnable = 1'b1; iKick = 1'b0;
        step(); step();
        chk("pre_dis", 32'(oRelay), 32'h0000);
        step();
        chk("dis_hold", 32'({oRelay, oWdtErr, oRun}), 32'({16'hFFFF, 1'b0, 1'b0}));

        // asynchronous reset mid-hold
        iEnable = 1'b0; iKick = 1'b1;
        repeat (3) step();
        iCom = '0;
        repeat (5) step();
        iCom = '1;
        repeat (8) step();
        chk("hold_mid", 32'(oRelay), 32'h0000);
        iRes = 1'b0;
        #1;
        chk("async_rst", 32'({oRelay, oWdtErr, oRun}), 32'({16'hFFFF, 1'b0, 1'b0}));
        model_reset();
        repeat (2) @(posedge iClk);
        #1;
        iRes = 1'b1; rst_edge = n;

        // randomized traffic against the model
        repeat (800) begin
            idx = int'($urandom_range(0, 99));
            if (idx < 15) begin
                idx = int'($urandom_range(0, WIDTH - 1));
                iCom[idx] = ~iCom[idx];
            end else if (idx < 17) begin
                iCom = 16'($urandom);
            end
            if ($urandom_range(0, 39) == 0) iKick = ~iKick;
            if ($urandom_range(0, 199) == 0) iEnable = ~iEnable;
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
